// File: rtl/clock_setter.sv
// Time-setting front end: debounces mode/up/down keys and walks an
// hour -> minute -> second edit sequence, ending in a one-cycle load strobe.
module clock_setter #(
  parameter logic [19:0] DEBOUNCE_CNT = 20'd999_999,
  parameter logic [24:0] BLINK_CNT    = 25'd24_999_999
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       key_mode,
  input  logic       key_up,
  input  logic       key_down,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       load,
  output logic       editing,
  output logic [5:0] blink_mask
);

  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} state_t;

  state_t      state, state_n;
  logic [2:0]  key_raw, key_press;
  logic [4:0]  hour_n;
  logic [5:0]  min_n, sec_n, mask_n;
  logic [24:0] blink_cnt, blink_cnt_n;
  logic        blink_off, blink_off_n, blink_clr, load_n;
  logic        mode_p, up_p, down_p;

  assign key_raw = {key_down, key_up, key_mode};

  for (genvar k = 0; k < 3; k++) begin : g_key
    logic        sync1, sync2, level, press;
    logic [19:0] stab_cnt;

    // Counter only runs while the synchronized level disagrees with the
    // accepted level; any return to agreement restarts the stability window.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sync1    <= 1'b1;
        sync2    <= 1'b1;
        level    <= 1'b1;
        press    <= 1'b0;
        stab_cnt <= '0;
      end else begin
        sync1 <= key_raw[k];
        sync2 <= sync1;
        press <= 1'b0;
        if (sync2 == level) begin
          stab_cnt <= '0;
        end else if (stab_cnt == DEBOUNCE_CNT) begin
          level    <= sync2;
          stab_cnt <= '0;
          press    <= ~sync2;
        end else begin
          stab_cnt <= stab_cnt + 20'd1;
        end
      end
    end

    assign key_press[k] = press;
  end

  assign mode_p = key_press[0];
  assign up_p   = key_press[1] & ~key_press[2] & ~mode_p;
  assign down_p = key_press[2] & ~key_press[1] & ~mode_p;

  always_comb begin
    state_n   = state;
    hour_n    = set_hour;
    min_n     = set_min;
    sec_n     = set_sec;
    load_n    = 1'b0;
    blink_clr = 1'b0;
    case (state)
      RUN: if (mode_p) begin
        hour_n    = cur_hour;
        min_n     = cur_min;
        sec_n     = cur_sec;
        state_n   = SET_HOUR;
        blink_clr = 1'b1;
      end
      SET_HOUR: begin
        if (mode_p) begin
          state_n   = SET_MIN;
          blink_clr = 1'b1;
        end else if (up_p) begin
          hour_n    = (set_hour >= 5'd23) ? 5'd0 : set_hour + 5'd1;
          blink_clr = 1'b1;
        end else if (down_p) begin
          hour_n    = (set_hour == 5'd0 || set_hour > 5'd23) ? 5'd23 : set_hour - 5'd1;
          blink_clr = 1'b1;
        end
      end
      SET_MIN: begin
        if (mode_p) begin
          state_n   = SET_SEC;
          blink_clr = 1'b1;
        end else if (up_p) begin
          min_n     = (set_min >= 6'd59) ? 6'd0 : set_min + 6'd1;
          blink_clr = 1'b1;
        end else if (down_p) begin
          min_n     = (set_min == 6'd0 || set_min > 6'd59) ? 6'd59 : set_min - 6'd1;
          blink_clr = 1'b1;
        end
      end
      SET_SEC: begin
        if (mode_p) begin
          state_n = RUN;
          load_n  = 1'b1;
        end else if (up_p) begin
          sec_n     = (set_sec >= 6'd59) ? 6'd0 : set_sec + 6'd1;
          blink_clr = 1'b1;
        end else if (down_p) begin
          sec_n     = (set_sec == 6'd0 || set_sec > 6'd59) ? 6'd59 : set_sec - 6'd1;
          blink_clr = 1'b1;
        end
      end
      default: state_n = RUN;
    endcase

    if (blink_clr) begin
      blink_cnt_n = '0;
      blink_off_n = 1'b0;
    end else if (blink_cnt == BLINK_CNT) begin
      blink_cnt_n = '0;
      blink_off_n = ~blink_off;
    end else begin
      blink_cnt_n = blink_cnt + 25'd1;
      blink_off_n = blink_off;
    end

    // Mask follows next-cycle state so it lines up with editing/set_*.
    mask_n = '0;
    if (blink_off_n) begin
      case (state_n)
        SET_HOUR: mask_n = 6'b110000;
        SET_MIN:  mask_n = 6'b001100;
        SET_SEC:  mask_n = 6'b000011;
        default:  mask_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= RUN;
      set_hour   <= '0;
      set_min    <= '0;
      set_sec    <= '0;
      load       <= 1'b0;
      editing    <= 1'b0;
      blink_mask <= '0;
      blink_cnt  <= '0;
      blink_off  <= 1'b0;
    end else begin
      state      <= state_n;
      set_hour   <= hour_n;
      set_min    <= min_n;
      set_sec    <= sec_n;
      load       <= load_n;
      editing    <= (state_n != RUN);
      blink_mask <= mask_n;
      blink_cnt  <= blink_cnt_n;
      blink_off  <= blink_off_n;
    end
  end

endmodule

// File: tb/tb_clock_setter.sv
// Directed bench for clock_setter with short debounce and blink periods.
module tb_clock_setter;

  logic       clk = 1'b0;
  logic       rstn;
  logic       key_mode, key_up, key_down;
  logic [4:0] cur_hour;
  logic [5:0] cur_min, cur_sec;
  logic [4:0] set_hour;
  logic [5:0] set_min, set_sec;
  logic       load, editing;
  logic [5:0] blink_mask;

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;

  clock_setter #(.DEBOUNCE_CNT(20'd3), .BLINK_CNT(25'd7)) dut (
    .clk(clk), .rstn(rstn),
    .key_mode(key_mode), .key_up(key_up), .key_down(key_down),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .load(load), .editing(editing), .blink_mask(blink_mask)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (load) load_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Key pressed at a falling edge takes effect on the 7th rising edge.
  task automatic press_start(input logic m, input logic u, input logic d);
    key_mode = ~m; key_up = ~u; key_down = ~d;
    wait_n(7);
  endtask

  task automatic press_end();
    key_mode = 1'b1; key_up = 1'b1; key_down = 1'b1;
    wait_n(7);
  endtask

  task automatic press(input logic m, input logic u, input logic d);
    press_start(m, u, d);
    press_end();
  endtask

  initial begin
    rstn = 1'b0;
    key_mode = 1'b1; key_up = 1'b1; key_down = 1'b1;
    cur_hour = 5'd8; cur_min = 6'd0; cur_sec = 6'd0;
    wait_n(3);
    chk("rst_hour", set_hour, 0);
    chk("rst_min", set_min, 0);
    chk("rst_sec", set_sec, 0);
    chk("rst_load", load, 0);
    chk("rst_editing", editing, 0);
    chk("rst_mask", blink_mask, 0);
    rstn = 1'b1;
    wait_n(3);

    // up in RUN is ignored
    press(0, 1, 0);
    chk("run_up_ignored", set_hour, 0);
    chk("run_up_editing", editing, 0);

    // Bounce rejection in SET_HOUR
    press(1, 0, 0);
    chk("bounce_enter_edit", editing, 1);
    chk("bounce_hour_copy", set_hour, 8);
    for (int i = 0; i < 10; i++) begin
      key_up = (i % 2 == 1);
      wait_n(2);
    end
    chk("bounce_no_event", set_hour, 8);
    key_up = 1'b0;
    wait_n(6);
    chk("bounce_before_settle", set_hour, 8);
    wait_n(1);
    chk("bounce_settled", set_hour, 9);
    press_end();
    wait_n(7);
    chk("bounce_single", set_hour, 9);
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    chk("bounce_load_cnt", load_cnt, 1);

    // Full edit 12:34:56 -> 14:33:57
    cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
    press(1, 0, 0);
    chk("edit_copy", {set_hour, set_min, set_sec}, {5'd12, 6'd34, 6'd56});
    press(0, 1, 0);
    press(0, 1, 0);
    chk("edit_hour_up2", set_hour, 14);
    press(1, 0, 0);
    press(0, 0, 1);
    chk("edit_min_down", set_min, 33);
    press(1, 0, 0);
    press(0, 1, 0);
    chk("edit_sec_up", set_sec, 57);
    chk("edit_no_load_yet", load_cnt, 1);
    press_start(1, 0, 0);
    chk("edit_load_high", load, 1);
    chk("edit_editing_low", editing, 0);
    chk("edit_result", {set_hour, set_min, set_sec}, {5'd14, 6'd33, 6'd57});
    press_end();
    chk("edit_load_once", load_cnt, 2);
    chk("edit_hold", {set_hour, set_min, set_sec}, {5'd14, 6'd33, 6'd57});
    chk("edit_editing_after", editing, 0);

    // Wrap cases
    cur_hour = 5'd23; cur_min = 6'd59; cur_sec = 6'd0;
    press(1, 0, 0);
    press(0, 1, 0);
    chk("wrap_hour_up", set_hour, 0);
    press(0, 0, 1);
    chk("wrap_hour_down", set_hour, 23);
    press(1, 0, 0);
    press(0, 1, 0);
    chk("wrap_min_up", set_min, 0);
    chk("wrap_hour_kept", set_hour, 23);
    press(1, 0, 0);
    press(0, 0, 1);
    chk("wrap_sec_down", set_sec, 59);
    press(1, 0, 0);
    chk("wrap_load_cnt", load_cnt, 3);

    // Blink and simultaneous events in SET_MIN
    cur_hour = 5'd10; cur_min = 6'd20; cur_sec = 6'd30;
    press(1, 0, 0);
    press(1, 0, 0);
    press(0, 1, 0);
    chk("blink_min_up", set_min, 21);
    chk("blink_after_up", blink_mask, 6'b000000);
    wait_n(1);
    chk("blink_on_1", blink_mask, 6'b001100);
    wait_n(7);
    chk("blink_on_8", blink_mask, 6'b001100);
    wait_n(1);
    chk("blink_off_9", blink_mask, 6'b000000);
    wait_n(8);
    chk("blink_on_17", blink_mask, 6'b001100);
    press(0, 1, 0);
    chk("blink_restart", blink_mask, 6'b000000);
    wait_n(1);
    chk("blink_restart_on", blink_mask, 6'b001100);
    chk("blink_min_up2", set_min, 22);
    press(0, 1, 1);
    chk("updown_dropped", set_min, 22);
    chk("updown_editing", editing, 1);
    press(1, 1, 0);
    chk("modeup_min_kept", set_min, 22);
    press(0, 1, 0);
    chk("modeup_in_sec", set_sec, 31);
    chk("modeup_min_still", set_min, 22);
    press_start(1, 0, 0);
    chk("sim_load", load, 1);
    chk("sim_result", {set_hour, set_min, set_sec}, {5'd10, 6'd22, 6'd31});
    press_end();
    chk("sim_load_cnt", load_cnt, 4);

    // Reset mid-edit in SET_SEC
    cur_hour = 5'd5; cur_min = 6'd6; cur_sec = 6'd7;
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    chk("rstmid_in_sec", editing, 1);
    chk("rstmid_sec_val", set_sec, 7);
    #3 rstn = 1'b0;
    #1;
    chk("rstmid_async", {set_hour, set_min, set_sec, load, editing, blink_mask}, '0);
    wait_n(3);
    rstn = 1'b1;
    wait_n(3);
    chk("rstmid_no_load", load_cnt, 4);
    press(0, 1, 0);
    chk("rstmid_run_up", set_hour, 0);
    chk("rstmid_run_editing", editing, 0);
    press(1, 0, 0);
    chk("rstmid_reenter", {set_hour, set_min, set_sec}, {5'd5, 6'd6, 6'd7});
    chk("rstmid_reenter_edit", editing, 1);
    chk("rstmid_mask_enter", blink_mask, 6'b000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
